pipe_register: RTL and testbench
================================

Name: pipe_register

Overview:
Parameterised D-type storage element with load enable, synchronous clear and asynchronous reset. It is the basic state primitive of the pipeline, used for:
- stage registers;
- single-bit decode flags, such as extracode-pending and index-pending, held across stalls and killed on flush;
- one-shot "just came out of reset" markers.

Parameters:
- WIDTH, default 32: bit width of D and Q; legal range 1 and up.
- RESET_VAL, default '0 (WIDTH bits): value loaded into Q on reset and on synchronous clear.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge except reset.
- rst_l, input, 1: one clock; reset is asynchronous and active-high. rst_l=1 forces Q to RESET_VAL immediately and holds it there.
- en, input, 1: load enable; 1 = capture D on the rising edge, 0 = hold.
- clear, input, 1: synchronous clear; 1 = load RESET_VAL on the rising edge.
- D, input, WIDTH: next-state data.
- Q, output, WIDTH: registered value.

Behaviour:
- Reset:
  - rst_l=1 sets Q = RESET_VAL asynchronously, with no clock needed.
  - While rst_l=1, Q stays RESET_VAL regardless of clk, en, clear and D.
  - Deassertion takes effect at the next rising clk edge with rst_l=0.
- Priority at each rising clk edge (rst_l=0):
  - clear=1: Q <= RESET_VAL. This applies regardless of en, so flush overrides stall.
  - clear=0, en=1: Q <= D.
  - clear=0, en=0: Q holds.
- Latency: one cycle. A D value sampled at edge N is visible on Q after edge N, and stays there until the next load, clear or reset.
- No combinational path from D, en or clear to Q. Q is driven only by the flop.
- Q has no X after reset; its reset value is RESET_VAL for every bit.
- Width rules:
  - RESET_VAL is truncated or zero-extended to WIDTH.
  - D is used bit-for-bit with no sign handling.
- One-shot usage (RESET_VAL=1, en=1, clear=0, D=0): Q=1 during reset and for the first cycle after deassertion, then 0 from the first rising edge onward.
- Reset mid-operation: asserting rst_l between edges changes Q immediately to RESET_VAL. Any pending load is discarded.
- Simultaneous clear=1 and en=1 with a D value: clear wins, so Q = RESET_VAL.
- No internal state besides Q. No handshake.

Test Plan:
1. Async reset, WIDTH=1, RESET_VAL=0:
   - Stimulus: Q=1, then raise rst_l between clock edges.
   - Required: Q=0 before the next edge, and Q stays 0 while rst_l=1 even with en=1, D=1.
2. Load/hold, WIDTH=15:
   - Stimulus: rst_l=0, en=1, D=15'o12345 for one edge, then en=0, D=15'o77777 for three edges.
   - Required: Q=15'o12345 after the first edge, unchanged after the next three.
3. Clear priority, WIDTH=1, RESET_VAL=0:
   - Stimulus: Q=1, then at one edge en=1, clear=1, D=1.
   - Required: Q=0.
   - Stimulus: repeat with en=0 (stalled), clear=1.
   - Required: Q=0.
4. Clear to non-zero reset value, WIDTH=8, RESET_VAL=8'hA5:
   - Stimulus: load 8'h3C, then pulse clear with en=0.
   - Required: Q=8'hA5.
5. One-shot marker, WIDTH=1, RESET_VAL=1, en=1, clear=0, D=0:
   - Stimulus: assert rst_l for 2 cycles, then release.
   - Required: Q=1 during reset and until the first rising edge after release, then Q=0 on every later cycle.
6. Reset mid-stream:
   - Stimulus: WIDTH=15, loading a new D every cycle; assert rst_l asynchronously mid-cycle.
   - Required: Q=RESET_VAL immediately. After release with en=1, the first load captures the D present at that edge.

Source files
------------

// File: rtl/pipe_register.sv
// pipe_register
// -------------
// Parameterised D-type storage element: the basic state primitive of the
// pipeline. It is used for stage registers, single-bit decode flags that must
// survive stalls but die on a flush, and one-shot "just left reset" markers.
//
// Parameters
//   WIDTH      bit width of D and Q (1 and up)
//   RESET_VAL  value forced onto Q by reset and by the synchronous clear;
//              declared WIDTH bits wide so an override is truncated or
//              zero-extended to WIDTH
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_l  in   1      asynchronous reset, active HIGH despite the name;
//                      while 1, Q is held at RESET_VAL
//   en     in   1      load enable: 1 = capture D at the edge, 0 = hold
//   clear  in   1      synchronous clear: 1 = load RESET_VAL at the edge,
//                      wins over en (a flush overrides a stall)
//   D      in   WIDTH  next-state data, taken bit-for-bit
//   Q      out  WIDTH  registered value, driven only by the flop
//
// There is no handshake and no state other than Q.

module pipe_register #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // The port keeps its historical name, but the reset is active-high:
    // rst_l = 1 forces Q to RESET_VAL immediately, without a clock edge.
    // Because the reset is in the sensitivity list, a load that is pending
    // when reset arrives is simply discarded.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            Q <= RESET_VAL;
        end else if (clear) begin
            Q <= RESET_VAL;
        end else if (en) begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_pipe_register.sv
// Testbench for pipe_register. It uses four instances with different
// WIDTH/RESET_VAL settings on one shared clock. Expected values go into a
// queue when the stimulus is driven. They are popped and checked when the
// DUT output is sampled, one time unit after the rising edge or after an
// asynchronous reset change.

module tb_pipe_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: WIDTH=1, RESET_VAL=0
    logic        rst_a, en_a, clr_a;
    logic [0:0]  d_a, q_a;
    // Instance b: WIDTH=15, RESET_VAL=15'o00007
    logic        rst_b, en_b, clr_b;
    logic [14:0] d_b, q_b;
    // Instance c: WIDTH=8, RESET_VAL=8'hA5
    logic        rst_c, en_c, clr_c;
    logic [7:0]  d_c, q_c;
    // Instance o: one-shot marker, WIDTH=1, RESET_VAL=1
    logic        rst_o, en_o, clr_o;
    logic [0:0]  d_o, q_o;

    pipe_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_a (
        .clk(clk), .rst_l(rst_a), .en(en_a), .clear(clr_a), .D(d_a), .Q(q_a)
    );
    pipe_register #(.WIDTH(15), .RESET_VAL(15'o00007)) u_b (
        .clk(clk), .rst_l(rst_b), .en(en_b), .clear(clr_b), .D(d_b), .Q(q_b)
    );
    pipe_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_c (
        .clk(clk), .rst_l(rst_c), .en(en_c), .clear(clr_c), .D(d_c), .Q(q_c)
    );
    pipe_register #(.WIDTH(1), .RESET_VAL(1'b1)) u_o (
        .clk(clk), .rst_l(rst_o), .en(en_o), .clear(clr_o), .D(d_o), .Q(q_o)
    );

    // Scoreboard
    logic [31:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] rnd;

    initial begin
        // Everything starts in reset.
        rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; d_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; d_b = '0;
        rst_c = 1'b1; en_c = 1'b0; clr_c = 1'b0; d_c = '0;
        rst_o = 1'b1; en_o = 1'b1; clr_o = 1'b0; d_o = 1'b0;
        expect_val(32'h0);    expect_val(32'h7);
        expect_val(32'hA5);   expect_val(32'h1);
        #1;
        check("reset_a", {31'b0, q_a});
        check("reset_b", {17'b0, q_b});
        check("reset_c", {24'b0, q_c});
        check("reset_o", {31'b0, q_o});

        // One-shot: reset held for two edges, then released between edges.
        expect_val(32'h1); tick(); check("oneshot_rst1", {31'b0, q_o});
        expect_val(32'h1); tick(); check("oneshot_rst2", {31'b0, q_o});
        rst_o = 1'b0; rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        expect_val(32'h1); #2; check("oneshot_release", {31'b0, q_o});
        expect_val(32'h0); tick(); check("oneshot_edge1", {31'b0, q_o});
        expect_val(32'h0); tick(); check("oneshot_edge2", {31'b0, q_o});

        // Async reset on the 1-bit instance.
        en_a = 1'b1; d_a = 1'b1;
        expect_val(32'h1); tick(); check("a_load1", {31'b0, q_a});
        #2; rst_a = 1'b1;
        expect_val(32'h0); #1; check("a_async_rst", {31'b0, q_a});
        expect_val(32'h0); tick(); check("a_rst_hold1", {31'b0, q_a});
        expect_val(32'h0); tick(); check("a_rst_hold2", {31'b0, q_a});
        rst_a = 1'b0;

        // Clear priority on the 1-bit instance.
        expect_val(32'h1); tick(); check("a_reload", {31'b0, q_a});
        clr_a = 1'b1;
        expect_val(32'h0); tick(); check("a_clear_en", {31'b0, q_a});
        clr_a = 1'b0;
        expect_val(32'h1); tick(); check("a_reload2", {31'b0, q_a});
        en_a = 1'b0; clr_a = 1'b1;
        expect_val(32'h0); tick(); check("a_clear_stall", {31'b0, q_a});
        clr_a = 1'b0; d_a = 1'b1;
        expect_val(32'h0); tick(); check("a_hold_after_clear", {31'b0, q_a});

        // Load/hold on the 15-bit instance.
        en_b = 1'b1; d_b = 15'o12345;
        expect_val(32'(15'o12345)); tick(); check("b_load", {17'b0, q_b});
        en_b = 1'b0; d_b = 15'o77777;
        for (int i = 0; i < 3; i++) begin
            expect_val(32'(15'o12345)); tick(); check("b_hold", {17'b0, q_b});
        end
        // D changing mid-cycle must not reach Q without an edge.
        en_b = 1'b1; d_b = 15'o55555;
        expect_val(32'(15'o12345)); #2; check("b_no_comb", {17'b0, q_b});

        // Clear to a non-zero reset value on the 8-bit instance.
        en_c = 1'b1; d_c = 8'h3C;
        expect_val(32'h3C); tick(); check("c_load", {24'b0, q_c});
        en_c = 1'b0; clr_c = 1'b1; d_c = 8'hFF;
        expect_val(32'hA5); tick(); check("c_clear", {24'b0, q_c});
        clr_c = 1'b0;
        expect_val(32'hA5); tick(); check("c_hold", {24'b0, q_c});
        en_c = 1'b1; clr_c = 1'b1; d_c = 8'h5A;
        expect_val(32'hA5); tick(); check("c_clear_wins", {24'b0, q_c});
        clr_c = 1'b0;

        // Reset mid-stream on the 15-bit instance.
        tick();
        for (int i = 0; i < 6; i++) begin
            rnd = 15'($urandom_range(0, 32767));
            d_b = rnd;
            expect_val({17'b0, rnd}); tick(); check("b_stream", {17'b0, q_b});
        end
        d_b = 15'($urandom_range(0, 32767));
        #2; rst_b = 1'b1;
        expect_val(32'h7); #1; check("b_midstream_rst", {17'b0, q_b});
        expect_val(32'h7); tick(); check("b_rst_held", {17'b0, q_b});
        rst_b = 1'b0;
        rnd = 15'($urandom_range(0, 32767));
        d_b = rnd;
        expect_val({17'b0, rnd}); tick(); check("b_first_load", {17'b0, q_b});

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
